// File: rtl/ps2_scan_buffer.sv
// rtl/ps2_scan_buffer.sv - PS/2 keyboard receiver with make-code filter and small key FIFO
module ps2_scan_buffer #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_AW     = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rd_key_code,
  output logic [7:0] key_code,
  output logic       kb_buf_empty,
  output logic       kb_buf_full,
  output logic       frame_err,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} rx_state_t;
  typedef enum logic {MAKE, BREAK} flt_state_t;

  logic c_s1, c_s2, d_s1, d_s2;
  logic filt_clk, fall_edge;
  logic [FW-1:0] filt_cnt;

  rx_state_t  rx_state;
  flt_state_t flt_state;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic [9:0]    shreg;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;

  logic       frame_ok, wr_req, rd_ok, wr_ok;
  logic [7:0] rx_byte;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
    end
  end

  // Filtered clock only moves after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      fall_edge <= 1'b0;
    end else begin
      fall_edge <= 1'b0;
      if (c_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk  <= c_s2;
        filt_cnt  <= '0;
        fall_edge <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // shreg after ten shifts: [9]=stop, [8]=parity, [7:0]=data
  assign rx_byte  = shreg[7:0];
  assign frame_ok = shreg[9] & (^shreg[8:0]);
  assign wr_req   = (rx_state == CHECK) && frame_ok && (flt_state == MAKE) &&
                    (rx_byte != 8'hF0) && (rx_byte != 8'hE0);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rx_state  <= IDLE;
      flt_state <= MAKE;
      bit_cnt   <= '0;
      timer     <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= wr_req && kb_buf_full && !rd_key_code;
      case (rx_state)
        IDLE: begin
          timer <= '0;
          if (fall_edge && !d_s2) begin
            rx_state <= DATA;
            bit_cnt  <= 4'd9;
          end
        end
        DATA: begin
          if (fall_edge) begin
            shreg <= {d_s2, shreg[9:1]};
            timer <= '0;
            if (bit_cnt == 4'd0) rx_state <= CHECK;
            else bit_cnt <= bit_cnt - 4'd1;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            rx_state  <= IDLE;
            timer     <= '0;
            frame_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          rx_state <= IDLE;
          if (!frame_ok) begin
            frame_err <= 1'b1;
          end else if (flt_state == BREAK) begin
            flt_state <= MAKE;
          end else if (rx_byte == 8'hF0) begin
            flt_state <= BREAK;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // A pop frees a slot, so a write into a full FIFO succeeds when paired with a read
  assign rd_ok = rd_key_code && !kb_buf_empty;
  assign wr_ok = wr_req && (!kb_buf_full || rd_ok);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= rx_byte;
  end

  assign kb_buf_empty = (count == '0);
  assign kb_buf_full  = (count == FULL_CNT);
  assign key_code     = kb_buf_empty ? 8'h00 : mem[rd_ptr];

endmodule
